// File: rtl/tu_fill_scheduler.sv
// Per-lane TU symbol scheduler: DATA for K slots, then FS/FILL/FE stuffing, K alternating N+1/N.
// Optional configuration checking is compiled in with `define TU_FILL_SCHED_CHECK_EN.
module tu_fill_scheduler #(
  parameter int TU_SIZE = 64,
  parameter int CW      = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       td_scheduler_start,
  input  logic       td_de,
  input  logic [5:0] td_tu_vld_data_size,
  input  logic [5:0] td_tu_alternate_up,
  input  logic [5:0] td_tu_alternate_down,
  output logic [2:0] tu_sym_sel,
  output logic       tu_data_rd,
  output logic       tu_start,
  output logic       tu_busy,
  output logic       tu_cfg_err
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_DATA, S_STUFF} state_t;

  localparam logic [2:0] SYM_NONE = 3'd0;
  localparam logic [2:0] SYM_DATA = 3'd1;
  localparam logic [2:0] SYM_FS   = 3'd2;
  localparam logic [2:0] SYM_FILL = 3'd3;
  localparam logic [2:0] SYM_FE   = 3'd4;

  localparam logic [CW-1:0] LAST = CW'(TU_SIZE - 1);
  localparam logic [CW:0]   TSW  = (CW+1)'(TU_SIZE);

  state_t        r_state, w_state;
  logic [5:0]    r_n, r_u, r_d, w_n, w_u, w_d;
  logic [CW-1:0] r_slot, w_slot, r_k, w_k;
  logic          r_up, w_up;
  logic [5:0]    r_pcnt, w_pcnt;
  logic [2:0]    r_sym, w_sym;
  logic          r_rd, r_start, w_start, r_busy, w_busy, r_err, w_err;
  logic          w_cfg_bad, w_tu_begin;
  logic [5:0]    w_cnt1, w_lim, w_oth;

  // Data count for one TU, clamped so a TU never exceeds TU_SIZE slots.
  function automatic logic [CW-1:0] k_of(input logic up, input logic [5:0] n);
    logic [CW:0] raw;
    raw  = (CW+1)'(n) + (CW+1)'(up);
    k_of = (raw > TSW) ? TSW[CW-1:0] : raw[CW-1:0];
  endfunction

  function automatic logic [2:0] sym_of(input logic [CW-1:0] slot, input logic [CW-1:0] k);
    if (slot < k)          sym_of = SYM_DATA;
    else if (slot == LAST) sym_of = SYM_FE;
    else if (slot == k)    sym_of = SYM_FS;
    else                   sym_of = SYM_FILL;
  endfunction

  always_comb begin
`ifdef TU_FILL_SCHED_CHECK_EN
    w_cfg_bad = (td_tu_vld_data_size == 6'd0) ||
                ((CW+1)'(td_tu_vld_data_size) > TSW) ||
                ((td_tu_alternate_up == 6'd0) && (td_tu_alternate_down == 6'd0));
`else
    w_cfg_bad = 1'b0;
`endif
  end

  always_comb begin
    w_state    = r_state;
    w_n        = r_n;
    w_u        = r_u;
    w_d        = r_d;
    w_slot     = r_slot;
    w_k        = r_k;
    w_up       = r_up;
    w_pcnt     = r_pcnt;
    w_sym      = SYM_NONE;
    w_start    = 1'b0;
    w_busy     = r_busy;
    w_err      = r_err;
    w_tu_begin = 1'b0;
    w_cnt1     = 6'(r_pcnt + 6'd1);
    w_lim      = r_up ? r_u : r_d;
    w_oth      = r_up ? r_d : r_u;

    if (td_scheduler_start) begin
      w_state = S_ARMED;
      w_n     = td_tu_vld_data_size;
      w_u     = td_tu_alternate_up;
      w_d     = td_tu_alternate_down;
      w_busy  = 1'b1;
      w_err   = w_cfg_bad;
    end else begin
      case (r_state)
        S_ARMED: begin
          if (td_de && !r_err) begin
            w_tu_begin = 1'b1;
            w_up       = (r_u != 6'd0);
            w_pcnt     = '0;
          end
        end
        S_DATA, S_STUFF: begin
          if (!td_de) begin
            w_state = S_ARMED;
          end else if (r_slot == LAST) begin
            // Phase flips after its count of TUs; an empty opposite phase keeps the current one.
            w_tu_begin = 1'b1;
            if (w_cnt1 >= w_lim) begin
              w_pcnt = '0;
              w_up   = (w_oth != 6'd0) ? ~r_up : r_up;
            end else begin
              w_pcnt = w_cnt1;
            end
          end else begin
            w_slot  = CW'(r_slot + 1'b1);
            w_sym   = sym_of(w_slot, r_k);
            w_state = (w_sym == SYM_DATA) ? S_DATA : S_STUFF;
          end
        end
        default: ;
      endcase
    end

    if (w_tu_begin) begin
      w_slot  = '0;
      w_k     = k_of(w_up, r_n);
      w_sym   = sym_of('0, w_k);
      w_start = 1'b1;
      w_state = (w_sym == SYM_DATA) ? S_DATA : S_STUFF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_n     <= '0;
      r_u     <= '0;
      r_d     <= '0;
      r_slot  <= '0;
      r_k     <= '0;
      r_up    <= 1'b0;
      r_pcnt  <= '0;
      r_sym   <= SYM_NONE;
      r_rd    <= 1'b0;
      r_start <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_n     <= w_n;
      r_u     <= w_u;
      r_d     <= w_d;
      r_slot  <= w_slot;
      r_k     <= w_k;
      r_up    <= w_up;
      r_pcnt  <= w_pcnt;
      r_sym   <= w_sym;
      r_rd    <= (w_sym == SYM_DATA);
      r_start <= w_start;
      r_busy  <= w_busy;
      r_err   <= w_err;
    end
  end

  assign tu_sym_sel = r_sym;
  assign tu_data_rd = r_rd;
  assign tu_start   = r_start;
  assign tu_busy    = r_busy;
  assign tu_cfg_err = r_err;

endmodule

// File: tb/tb_tu_fill_scheduler.sv
// Directed self-checking bench for tu_fill_scheduler; a second TU_SIZE=32 instance covers K clamping.
module tb_tu_fill_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       de = 1'b0;
  logic [5:0] n_cfg = '0, u_cfg = '0, d_cfg = '0;
  logic [2:0] sym, sym32;
  logic       rd, rd32, tus, tus32, busy, busy32, err, err32;

  int n_cmp = 0;
  int n_err = 0;
  int pops  = 0;

  always #5 clk = ~clk;

  tu_fill_scheduler #(.TU_SIZE(64), .CW(7)) dut (
    .clk(clk), .rst_n(rst_n), .td_scheduler_start(start), .td_de(de),
    .td_tu_vld_data_size(n_cfg), .td_tu_alternate_up(u_cfg), .td_tu_alternate_down(d_cfg),
    .tu_sym_sel(sym), .tu_data_rd(rd), .tu_start(tus), .tu_busy(busy), .tu_cfg_err(err)
  );

  tu_fill_scheduler #(.TU_SIZE(32), .CW(6)) dut32 (
    .clk(clk), .rst_n(rst_n), .td_scheduler_start(start), .td_de(de),
    .td_tu_vld_data_size(n_cfg), .td_tu_alternate_up(u_cfg), .td_tu_alternate_down(d_cfg),
    .tu_sym_sel(sym32), .tu_data_rd(rd32), .tu_start(tus32), .tu_busy(busy32), .tu_cfg_err(err32)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected symbol of a 64-slot TU carrying k data symbols.
  function automatic int exp_sym(input int s, input int k);
    if (s < k)  return 1;
    if (s == 63) return 4;
    if (s == k) return 2;
    return 3;
  endfunction

  // Packed {tu_start, tu_data_rd, tu_sym_sel} for one slot.
  function automatic int exp_word(input int s, input int k);
    int e;
    e = exp_sym(s, k);
    return ((s == 0) ? 16 : 0) + ((e == 1) ? 8 : 0) + e;
  endfunction

  function automatic int obs_word();
    return int'({tus, rd, sym});
  endfunction

  task automatic run_part(input int k, input int nslots);
    for (int s = 0; s < nslots; s++) begin
      @(negedge clk);
      pops += int'(rd);
      check($sformatf("tu_k%0d_slot%0d", k, s), obs_word(), exp_word(s, k));
    end
  endtask

  task automatic run_tu(input int k);
    run_part(k, 64);
  endtask

  // Called at a negedge; pulses start for one cycle and checks the armed state.
  task automatic do_start(input int n, input int u, input int d, input int exp_err);
    n_cfg = 6'(n);
    u_cfg = 6'(u);
    d_cfg = 6'(d);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("armed_none", obs_word(), 0);
    check("armed_busy", int'(busy), 1);
    check("armed_cfg_err", int'(err), exp_err);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    check("reset_outputs", int'({tus, rd, sym, busy, err}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // de without a start pulse must not schedule anything
    de = 1'b1;
    repeat (3) @(negedge clk);
    check("de_before_start_sym", obs_word(), 0);
    check("de_before_start_busy", int'(busy), 0);

    // N=40 U=1 D=1, start coincident with de high
    do_start(40, 1, 1, 0);
    pops = 0;
    run_tu(41);
    run_tu(40);
    run_tu(41);
    run_tu(40);
    check("pops_256_cycles", pops, 162);

    // Restart while running: start overrides de, first TU one cycle later
    do_start(63, 1, 0, 0);
    run_tu(64);
    run_tu(64);

    do_start(62, 0, 1, 0);
    run_tu(62);
    run_tu(62);

    do_start(63, 0, 1, 0);
    run_tu(63);
    run_tu(63);

    // Abort at slot 30, resume 10 cycles later in the up-phase
    do_start(40, 1, 1, 0);
    run_part(41, 31);
    de = 1'b0;
    @(negedge clk);
    check("abort_next_cycle", obs_word(), 0);
    repeat (9) @(negedge clk);
    check("abort_held_none", obs_word(), 0);
    check("abort_busy", int'(busy), 1);
    de = 1'b1;
    run_tu(41);
    run_tu(40);

    // Asynchronous reset at slot 50
    run_part(41, 51);
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs", int'({tus, rd, sym, busy, err}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post_reset_de_only", obs_word(), 0);
    check("post_reset_busy", int'(busy), 0);

`ifdef TU_FILL_SCHED_CHECK_EN
    do_start(0, 1, 1, 1);
    repeat (5) @(negedge clk);
    check("cfg_err_sym_none", obs_word(), 0);
    check("cfg_err_sticky", int'(err), 1);
    do_start(32, 0, 1, 0);
    run_tu(32);
    run_tu(32);
`else
    // N=0 gives all-stuff TUs, no error flag
    do_start(0, 0, 1, 0);
    run_tu(0);
    run_tu(0);
    check("no_check_cfg_err", int'(err), 0);

    // U=D=0 behaves as U=0 D=1
    do_start(10, 0, 0, 0);
    run_tu(10);
    run_tu(10);

    // Clamp: N+1 and N both exceed TU_SIZE=32 on the narrow instance
    do_start(40, 1, 1, 0);
    for (int s = 0; s < 64; s++) begin
      @(negedge clk);
      check($sformatf("clamp32_slot%0d", s), int'({tus32, rd32, sym32}),
            ((s % 32) == 0) ? 25 : 9);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tu_fill_scheduler.md
# tu_fill_scheduler

Per-lane transfer-unit (TU) symbol scheduler for the isochronous main-link datapath. It sits downstream of the timing decision block and alongside the iso scheduler. During each active line it sequences every TU slot into valid-data symbols followed by stuffing (FS, fill, FE). The valid-data count alternates between size+1 and size, so the average link rate matches the stream bandwidth. Its outputs drive the pixel-FIFO pop and the stream symbol mux.

## Interface
Parameters:
- TU_SIZE, 64, symbols per TU per lane (legal 32..64).
- CW, 7, width of the internal TU slot counter; must satisfy 2^CW > TU_SIZE.

Ports:
- clk  in  1  single clock domain.
- rst_n  in  1  asynchronous active-low reset.
- td_scheduler_start  in  1  one-cycle pulse that latches the configuration and arms the block.
- td_de  in  1  active-line window; TUs are scheduled only while high.
- td_tu_vld_data_size  in  6  nominal valid symbols per TU (N).
- td_tu_alternate_up  in  6  number of consecutive TUs carrying N+1 data symbols (U).
- td_tu_alternate_down  in  6  number of consecutive TUs carrying N data symbols (D).
- tu_sym_sel  out  3  symbol this cycle: 0 NONE, 1 DATA, 2 FS, 3 FILL, 4 FE.
- tu_data_rd  out  1  pixel-FIFO pop; equals (tu_sym_sel==DATA).
- tu_start  out  1  pulse on the first symbol of every TU.
- tu_busy  out  1  high from the start pulse until the next reset.
- tu_cfg_err  out  1  sticky configuration error (see Configuration).

## Operation
- The FSM has four states: IDLE, ARMED, DATA, STUFF.
- IDLE → ARMED on td_scheduler_start. On that edge the block latches N, U and D into shadow registers. Inputs are ignored at all other times.
- ARMED → DATA when td_de is sampled high. The slot counter resets to 0 and the alternation phase resets to the up-phase with phase count 0.
- TU data count K:
  - K = N+1 while in the up-phase.
  - K = N while in the down-phase.
  - Phase switches after U (or D) completed TUs.
  - If U=0 the up-phase is skipped. If D=0 the down-phase is skipped.
- DATA state emits DATA for slots 0..K-1, then moves to STUFF.
- STUFF state emits the remaining S = TU_SIZE−K slots:
  - S=0: STUFF is skipped; the next TU starts immediately.
  - S=1: FE only.
  - S=2: FS, FE.
  - S≥3: FS, then S−2 FILL, then FE.
- After the last slot, the slot counter wraps to 0, tu_start pulses and the next TU begins. A TU always spans exactly TU_SIZE cycles.
- td_de low in any state other than IDLE or ARMED:
  - Abort the current TU; the partial TU is not completed.
  - Go to ARMED.
  - Output NONE from the next cycle.
- A new td_scheduler_start in any state re-latches the configuration and goes to ARMED. It takes priority over td_de.
- K is clamped to TU_SIZE. If N+1 exceeds TU_SIZE, the up-phase TU carries TU_SIZE data symbols.

## Timing
- All outputs are registered.
- Reset values: tu_sym_sel=0, tu_data_rd=0, tu_start=0, tu_busy=0, tu_cfg_err=0. The FSM is in IDLE.
- Start latency: first DATA symbol and tu_start appear on the cycle after td_de is first sampled high in ARMED.
- Abort latency: td_de sampled low at cycle t gives NONE at t+1. A pending tu_start is suppressed.
- tu_data_rd is cycle-aligned with tu_sym_sel==DATA, with zero extra latency.
- Reset asserted mid-TU: all outputs clear immediately (asynchronous). After release the block is in IDLE and the latched configuration is lost.
- Start pulse coincident with td_de high: latch first, enter ARMED. The first TU starts one cycle later.

## Configuration
- Macro TU_FILL_SCHED_CHECK_EN.
- Defined: on every start pulse, the block checks for N=0, N>TU_SIZE, or U=D=0.
  - Any violation sets tu_cfg_err, which stays set until reset or until a start pulse with a legal configuration.
  - While tu_cfg_err is set, the block stays in ARMED and outputs NONE.
- Undefined: no checks are made and tu_cfg_err is tied 0.
  - N=0 gives all-stuff TUs.
  - U=D=0 behaves as U=0, D=1.
  - Clamping still applies.

## Test plan
- TU_SIZE=64, N=40, U=1, D=1, start, then de high for 256 cycles → expected TU pattern:
  - TU0: 41 DATA, FS, 21 FILL, FE.
  - TU1: 40 DATA, FS, 22 FILL, FE.
  - Pattern repeats.
  - tu_start every 64 cycles.
  - 162 pops in total.
- N=63, U=1, D=0 → every TU is 64 DATA with no stuffing. N=62, D=1, U=0 → 62 DATA, FS, FE.
- N=63, U=0, D=1 → 63 DATA then a single FE per TU.
- de drops at slot 30 of TU0, then rises 10 cycles later → NONE from the next cycle. The next TU restarts in the up-phase at slot 0 with K=N+1.
- rst_n asserted at slot 50 → all outputs are 0 in the same cycle. After release, de alone does nothing until a new start pulse.
- With TU_FILL_SCHED_CHECK_EN, start with N=0 → tu_cfg_err=1 and tu_sym_sel stays NONE under de. A second start with N=32 clears the flag and 32 DATA/32 stuff TUs follow.
